// File: rtl/rx_unstuff_shift_if.sv
// ---------------------------------------------------------------------------
// rx_unstuff_shift_if
// Bundles the serial receive side of the unstuff/shift stage.
//   d_orig       : NRZI-decoded serial bit from the decode stage
//   shift_enable : one-cycle strobe marking the sample point of d_orig/eop
//   eop          : end-of-packet, meaningful only while shift_enable=1
//   rx_data      : last completed byte, LSB received first
//   byte_ready   : one-cycle pulse when rx_data is updated
//   partial_err  : one-cycle pulse when eop arrives with a partial byte
//   stuff_err    : one-cycle pulse on a bit-stuff violation
// Modports: master drives the serial inputs, slave is the unstuff stage.
// ---------------------------------------------------------------------------
interface rx_unstuff_shift_if;
    logic       d_orig;
    logic       shift_enable;
    logic       eop;
    logic [7:0] rx_data;
    logic       byte_ready;
    logic       partial_err;
    logic       stuff_err;

    modport master (
        output d_orig, shift_enable, eop,
        input  rx_data, byte_ready, partial_err, stuff_err
    );

    modport slave (
        input  d_orig, shift_enable, eop,
        output rx_data, byte_ready, partial_err, stuff_err
    );
endinterface

// File: rtl/rx_unstuff_shift.sv
// ---------------------------------------------------------------------------
// rx_unstuff_shift
// Removes stuffed bits from the decoded serial stream and assembles bytes,
// LSB first.
// Ports:
//   clk   : system clock, all updates on the rising edge
//   n_rst : asynchronous active-low reset
//   bus   : rx_unstuff_shift_if.slave (d_orig, shift_enable, eop in;
//           rx_data, byte_ready, partial_err, stuff_err out)
// Handshake: there is no back-pressure. A cycle with shift_enable=1 is one
// bit-sample; the stage always accepts it. Every output pulse is registered
// and appears in the cycle after the strobe that caused it, lasting one cycle.
// Optional feature: define RX_STUFF_ERR_EN to flag a stuff bit of value 1 on
// stuff_err and drop the partial byte. Otherwise stuff_err is tied to 0.
// ---------------------------------------------------------------------------
module rx_unstuff_shift (
    input  logic                 clk,
    input  logic                 n_rst,
    rx_unstuff_shift_if.slave    bus
);

    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [2:0] bit_cnt;
    logic [2:0] ones_cnt;
    logic [7:0] rx_data_r;
    logic       byte_ready_r;
    logic       partial_err_r;
`ifdef RX_STUFF_ERR_EN
    logic       stuff_err_r;
`endif

    // New bit enters at the top so that after eight shifts the first bit
    // received sits in bit 0.
    always_comb begin
        shift_next = {bus.d_orig, shift_reg[7:1]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg     <= 8'h00;
            bit_cnt       <= 3'd0;
            ones_cnt      <= 3'd0;
            rx_data_r     <= 8'h00;
            byte_ready_r  <= 1'b0;
            partial_err_r <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            stuff_err_r   <= 1'b0;
`endif
        end else begin
            byte_ready_r  <= 1'b0;
            partial_err_r <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            stuff_err_r   <= 1'b0;
`endif
            if (bus.shift_enable) begin
                if (bus.eop) begin
                    // End of packet wins over everything; d_orig is ignored.
                    partial_err_r <= (bit_cnt != 3'd0);
                    bit_cnt       <= 3'd0;
                    ones_cnt      <= 3'd0;
                    shift_reg     <= 8'h00;
                end else if (ones_cnt == 3'd6) begin
                    // Bit after six ones is a stuff bit and never data.
                    ones_cnt <= 3'd0;
`ifdef RX_STUFF_ERR_EN
                    if (bus.d_orig) begin
                        stuff_err_r <= 1'b1;
                        bit_cnt     <= 3'd0;
                        shift_reg   <= 8'h00;
                    end
`endif
                end else begin
                    shift_reg <= shift_next;
                    bit_cnt   <= bit_cnt + 3'd1;
                    ones_cnt  <= bus.d_orig ? (ones_cnt + 3'd1) : 3'd0;
                    if (bit_cnt == 3'd7) begin
                        rx_data_r    <= shift_next;
                        byte_ready_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rx_data     = rx_data_r;
    assign bus.byte_ready  = byte_ready_r;
    assign bus.partial_err = partial_err_r;
`ifdef RX_STUFF_ERR_EN
    assign bus.stuff_err   = stuff_err_r;
`else
    assign bus.stuff_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// ---------------------------------------------------------------------------
// tb_rx_unstuff_shift
// Directed bench for rx_unstuff_shift. Bits are strobed one at a time with
// an idle cycle between strobes; a negedge monitor scores every byte_ready
// against an expected queue and counts error pulses.
// ---------------------------------------------------------------------------
module tb_rx_unstuff_shift;

    logic clk;
    logic n_rst;

    rx_unstuff_shift_if bus ();

    rx_unstuff_shift dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int byte_cnt     = 0;
    int partial_cnt  = 0;
    int stuff_cnt    = 0;
    int exp_bytes    = 0;
    int exp_partial  = 0;
    int exp_stuff    = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.byte_ready) begin
                byte_cnt++;
                if (exp_q.size() == 0)
                    check("unexpected_byte_ready", 32'd1, 32'd0);
                else
                    check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (bus.partial_err) partial_cnt++;
            if (bus.stuff_err)   stuff_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic d, input logic e);
        @(negedge clk);
        bus.d_orig       = d;
        bus.eop          = e;
        bus.shift_enable = 1'b1;
        @(negedge clk);
        bus.shift_enable = 1'b0;
        bus.eop          = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i], 1'b0);
    endtask

    task automatic check_counts(input string tag);
        // Allow the last pulse to be observed by the monitor.
        @(negedge clk);
        check({tag, "_bytes"},   byte_cnt,    exp_bytes);
        check({tag, "_partial"}, partial_cnt, exp_partial);
        check({tag, "_stuff"},   stuff_cnt,   exp_stuff);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] held;

    initial begin
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;
        bus.shift_enable = 1'b0;
        n_rst            = 1'b0;
        #12;
        check("rst_rx_data",     {24'd0, bus.rx_data}, 32'h00);
        check("rst_byte_ready",  {31'd0, bus.byte_ready}, 32'd0);
        check("rst_partial_err", {31'd0, bus.partial_err}, 32'd0);
        check("rst_stuff_err",   {31'd0, bus.stuff_err}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // 1,0,1,0,0,1,0,1 first to last -> 0xA5
        exp_q.push_back(8'hA5); exp_bytes++;
        send_bits(16'b1010_0101, 8);
        check_counts("a5");
        send_bit(1'b0, 1'b1);                // eop on byte boundary: silent
        check_counts("eop_clean");

        // six ones, stuffed 0, two ones -> 0xFF
        exp_q.push_back(8'hFF); exp_bytes++;
        send_bits(16'b11_1111, 6);
        send_bit(1'b0, 1'b0);
        send_bits(16'b11, 2);
        check_counts("stuff0");
        send_bit(1'b0, 1'b1);
        check_counts("eop_clean2");

        // three bits, eop -> partial_err; then 0x3C
        send_bits(16'b101, 3);
        send_bit(1'b1, 1'b1);
        exp_partial++;
        check_counts("partial");
        exp_q.push_back(8'h3C); exp_bytes++;
        send_bits(16'h003C, 8);
        check_counts("b3c");

        // six ones, stuff bit 1, two ones, then eop
        send_bits(16'b11_1111, 6);
        send_bit(1'b1, 1'b0);
`ifdef RX_STUFF_ERR_EN
        exp_stuff++;
        send_bits(16'b11, 2);
        send_bit(1'b0, 1'b1);
        exp_partial++;
`else
        exp_q.push_back(8'hFF); exp_bytes++;
        send_bits(16'b11, 2);
        send_bit(1'b0, 1'b1);
`endif
        check_counts("stuff1");

        // reset between edges after five bits
        send_bits(16'b10110, 5);
        #3 n_rst = 1'b0;
        #1;
        check("mid_rst_rx_data",    {24'd0, bus.rx_data}, 32'h00);
        check("mid_rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("mid_rst_partial",    {31'd0, bus.partial_err}, 32'd0);
        check("mid_rst_stuff",      {31'd0, bus.stuff_err}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.push_back(8'h81); exp_bytes++;
        send_bits(16'h0081, 8);
        check_counts("b81");

        // idle: shift_enable low, inputs toggling
        held = bus.rx_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.d_orig = $urandom_range(0, 1);
            bus.eop    = $urandom_range(0, 1);
        end
        bus.eop = 1'b0;
        check("idle_rx_data", {24'd0, bus.rx_data}, {24'd0, held});
        check_counts("idle");
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

    // Watchdog: the stimulus is short, so a long run means something hung.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rx_unstuff_shift.md
RX_UNSTUFF_SHIFT -- requirements
Module: rx_unstuff_shift

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: n_rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: d_orig  input  1  NRZI-decoded serial bit from decode stage.
REQ-004 SHALL have port: shift_enable  input  1  one-cycle strobe marking the bit-sample point for d_orig.
REQ-005 SHALL have port: eop  input  1  end-of-packet indication, sampled only when shift_enable=1.
REQ-006 SHALL have port: rx_data  output  8  last completed byte, LSB received first.
REQ-007 SHALL have port: byte_ready  output  1  one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port: partial_err  output  1  one-cycle pulse when eop arrives with a partial byte.
REQ-009 SHALL have port: stuff_err  output  1  one-cycle pulse on bit-stuff violation (see Configuration).

Function
REQ-010 SHALL keep ones_cnt (3 bit), consecutive 1 data bits accepted, and bit_cnt (3 bit), data bits held in the shift register.
REQ-011 SHALL change internal state only in cycles with shift_enable=1; outputs pulse only in the cycle after such a cycle.
REQ-012 Priority per strobe SHALL be: eop, then stuff-bit handling, then data shift.
REQ-013 eop=1 with shift_enable=1 SHALL clear ones_cnt and bit_cnt and discard the partial byte; d_orig is ignored that cycle.
REQ-014 eop=1 with bit_cnt!=0 SHALL pulse partial_err the next cycle; eop with bit_cnt=0 SHALL pulse nothing.
REQ-015 A strobe with ones_cnt=6 SHALL treat d_orig as a stuff bit: bit discarded, ones_cnt cleared, bit_cnt unchanged.
REQ-016 Any other strobe SHALL shift d_orig into bit 7 of an 8-bit register, shifting right (LSB-first), and increment bit_cnt modulo 8.
REQ-017 A shifted 1 SHALL increment ones_cnt; a shifted 0 SHALL clear ones_cnt.
REQ-018 ones_cnt SHALL carry across byte boundaries.
REQ-019 On the strobe that shifts the 8th bit (bit_cnt 7->0), the next cycle SHALL present the completed byte on rx_data with byte_ready=1 for exactly one cycle.
REQ-020 rx_data SHALL hold its value until the next completed byte or reset.
REQ-021 shift_enable=0 with eop=1 SHALL have no effect.

Reset
REQ-022 n_rst=0 SHALL immediately, regardless of clk, force rx_data=0x00, byte_ready=0, partial_err=0, stuff_err=0, ones_cnt=0, bit_cnt=0 and shift register=0x00.
REQ-023 Reset mid-byte SHALL discard the partial byte with no pulse on any output after release.

Configuration
REQ-024 Macro RX_STUFF_ERR_EN SHALL control stuff-violation detection.
REQ-025 With RX_STUFF_ERR_EN defined, a stuff bit (REQ-015) equal to 1 SHALL pulse stuff_err the next cycle and SHALL also clear bit_cnt, discarding the partial byte.
REQ-026 Without RX_STUFF_ERR_EN, stuff_err SHALL be constant 0 and every stuff bit SHALL be discarded per REQ-015 regardless of value.

Verification
REQ-027 Strobe bits 1,0,1,0,0,1,0,1 (first to last) -> byte_ready one cycle after the 8th strobe, rx_data=0xA5.
REQ-028 Strobe 1,1,1,1,1,1, stuff 0, then 1,1 -> rx_data=0xFF on byte_ready; the stuffed 0 does not appear and bit count is unaffected.
REQ-029 Strobe 3 data bits, then eop=1 with shift_enable=1 -> partial_err pulse, no byte_ready; next 8 bits 0x3C form rx_data=0x3C.
REQ-030 Six 1s then stuff bit 1 -> with RX_STUFF_ERR_EN, stuff_err pulse and no byte_ready for that byte; without it, stuff_err stays 0 and the byte continues.
REQ-031 Assert n_rst=0 between clock edges after 5 bits -> outputs 0 immediately; after release, 8 bits 0x81 -> rx_data=0x81, single byte_ready.
REQ-032 Hold shift_enable=0 for 20 cycles while toggling d_orig and eop -> no output change, no pulses.
